// File: rtl/slow_tick_timer.sv
// Down-counting game timer stepped by rising edges of the divided usr_clk, sampled in the clk domain.
// Optional macro TIMER_AUTORELOAD_EN: the terminal step reloads the last loaded value instead of stopping.
module slow_tick_timer #(
   parameter int WIDTH    = 16,
   parameter int PRESCALE = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             usr_clk,
   input  logic             load,
   input  logic [WIDTH-1:0] load_value,
   input  logic             start,
   input  logic             pause,
   output logic [WIDTH-1:0] count,
   output logic [1:0]       state,
   output logic             running,
   output logic             expired
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      PAUSED = 2'd2,
      DONE   = 2'd3
   } state_t;

   localparam int            PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

   state_t           cur_state;
   state_t           next_state;
   logic [WIDTH-1:0] count_next;
   logic [PW-1:0]    pre_cnt;
   logic [PW-1:0]    pre_next;
   logic             expired_next;
   logic             usr_q;
   logic             tick;
   logic             step;

`ifdef TIMER_AUTORELOAD_EN
   logic [WIDTH-1:0] reload_reg;
   logic [WIDTH-1:0] reload_next;
`endif

   // usr_q keeps tracking usr_clk through reset so a high usr_clk at release is not seen as an edge.
   always_ff @(posedge clk) begin
      usr_q <= usr_clk;
   end

   assign tick  = usr_clk & ~usr_q;
   assign step  = tick & (pre_cnt == PRE_LAST);
   assign state = cur_state;

   always_ff @(posedge clk) begin
      if (reset) begin
         cur_state  <= IDLE;
         count      <= '0;
         pre_cnt    <= '0;
         expired    <= 1'b0;
         running    <= 1'b0;
`ifdef TIMER_AUTORELOAD_EN
         reload_reg <= '0;
`endif
      end else begin
         cur_state  <= next_state;
         count      <= count_next;
         pre_cnt    <= pre_next;
         expired    <= expired_next;
         running    <= (next_state == RUN);
`ifdef TIMER_AUTORELOAD_EN
         reload_reg <= reload_next;
`endif
      end
   end

   // Control priority: load, then pause, then start, then the prescaled step.
   always_comb begin
      next_state   = cur_state;
      count_next   = count;
      pre_next     = pre_cnt;
      expired_next = 1'b0;
`ifdef TIMER_AUTORELOAD_EN
      reload_next  = reload_reg;
`endif

      if (load) begin
         count_next = load_value;
         pre_next   = '0;
         next_state = IDLE;
`ifdef TIMER_AUTORELOAD_EN
         reload_next = load_value;
`endif
      end else begin
         case (cur_state)
            IDLE: begin
               if (!pause && start && (count != '0)) begin
                  next_state = RUN;
               end
            end

            RUN: begin
               if (pause) begin
                  next_state = PAUSED;
               end else if (step) begin
                  pre_next = '0;
                  if (count > WIDTH'(1)) begin
                     count_next = count - WIDTH'(1);
                  end else begin
                     expired_next = 1'b1;
`ifdef TIMER_AUTORELOAD_EN
                     if (reload_reg != '0) begin
                        count_next = reload_reg;
                     end else begin
                        count_next = '0;
                        next_state = DONE;
                     end
`else
                     count_next = '0;
                     next_state = DONE;
`endif
                  end
               end else if (tick) begin
                  pre_next = pre_cnt + PW'(1);
               end
            end

            PAUSED: begin
               if (!pause && start) begin
                  next_state = RUN;
               end
            end

            DONE: begin
               count_next = '0;
            end

            default: begin
               next_state = IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_slow_tick_timer.sv
// Directed bench for slow_tick_timer: usr_clk is driven in lockstep with clk (period 32) by the stimulus thread.
// Honors TIMER_AUTORELOAD_EN to select the reload scenario instead of the run-to-DONE scenario.
module tb_slow_tick_timer;

   localparam int WIDTH    = 16;
   localparam int PRESCALE = 4;

   logic             clk        = 1'b0;
   logic             reset      = 1'b1;
   logic             usr_clk    = 1'b1;
   logic             load       = 1'b0;
   logic [WIDTH-1:0] load_value = '0;
   logic             start      = 1'b0;
   logic             pause      = 1'b0;
   logic [WIDTH-1:0] count;
   logic [1:0]       state;
   logic             running;
   logic             expired;

   int checks = 0;
   int errors = 0;
   int ph     = 16;
   int exp_q[$];

   slow_tick_timer #(.WIDTH(WIDTH), .PRESCALE(PRESCALE)) dut (
      .clk       (clk),
      .reset     (reset),
      .usr_clk   (usr_clk),
      .load      (load),
      .load_value(load_value),
      .start     (start),
      .pause     (pause),
      .count     (count),
      .state     (state),
      .running   (running),
      .expired   (expired)
   );

   always #5 clk = ~clk;

   initial begin
      #5_000_000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
      end
   endtask

   // One clk cycle; usr_clk rises when ph becomes 16 and the DUT consumes that tick on the next edge.
   task automatic clkStep();
      @(posedge clk);
      #1;
      ph      = (ph + 1) % 32;
      usr_clk = (ph >= 16);
   endtask

   task automatic alignPhase();
      while (ph != 0) clkStep();
   endtask

   task automatic oneTick();
      do clkStep(); while (ph != 16);
      clkStep();
   endtask

   task automatic applyStimulus(input logic l, input logic [WIDTH-1:0] v, input logic s, input logic p);
      load       = l;
      load_value = v;
      start      = s;
      pause      = p;
      clkStep();
      load  = 1'b0;
      start = 1'b0;
      pause = 1'b0;
   endtask

   task automatic waitChange(input int max, output int n);
      logic [WIDTH-1:0] prev;
      prev = count;
      n    = 0;
      do begin
         clkStep();
         n++;
      end while ((count == prev) && (n < max));
   endtask

   initial begin
      int n;
      int e;

      $display("[TB] reset with usr_clk held high");
      repeat (3) clkStep();
      reset = 1'b0;
      checkOutput("reset_tick", dut.tick, 0);
      checkOutput("reset_count", count, 0);
      checkOutput("reset_state", state, 0);
      checkOutput("reset_expired", expired, 0);
      checkOutput("reset_running", running, 0);
      clkStep();
      checkOutput("post_reset_state", state, 0);
      checkOutput("post_reset_pre", dut.pre_cnt, 0);

`ifndef TIMER_AUTORELOAD_EN
      $display("[TB] load 3 and run to DONE");
      alignPhase();
      applyStimulus(1'b1, 16'd3, 1'b0, 1'b0);
      applyStimulus(1'b0, 16'd0, 1'b1, 1'b0);
      checkOutput("run_state", state, 1);
      checkOutput("run_running", running, 1);
      checkOutput("run_count", count, 3);
      exp_q.push_back(2);
      exp_q.push_back(1);
      exp_q.push_back(0);
      waitChange(200, n);
      e = exp_q.pop_front();
      checkOutput("first_step_count", count, e);
      checkOutput("first_step_latency", n, 111);
      waitChange(200, n);
      e = exp_q.pop_front();
      checkOutput("second_step_count", count, e);
      checkOutput("second_step_interval", n, 128);
      waitChange(200, n);
      e = exp_q.pop_front();
      checkOutput("final_step_count", count, e);
      checkOutput("final_step_interval", n, 128);
      checkOutput("expired_high", expired, 1);
      checkOutput("done_state", state, 3);
      checkOutput("done_running", running, 0);
      clkStep();
      checkOutput("expired_low", expired, 0);
      checkOutput("done_hold_count", count, 0);
      applyStimulus(1'b0, 16'd0, 1'b1, 1'b0);
      checkOutput("done_ignores_start", state, 3);
      applyStimulus(1'b0, 16'd0, 1'b0, 1'b1);
      checkOutput("done_ignores_pause", state, 3);
`else
      $display("[TB] autoreload with load 2");
      alignPhase();
      applyStimulus(1'b1, 16'd2, 1'b0, 1'b0);
      applyStimulus(1'b0, 16'd0, 1'b1, 1'b0);
      checkOutput("ar_running_start", running, 1);
      exp_q.push_back(1);
      exp_q.push_back(2);
      exp_q.push_back(1);
      exp_q.push_back(2);
      for (int i = 0; i < 4; i++) begin
         waitChange(200, n);
         e = exp_q.pop_front();
         checkOutput("ar_count", count, e);
         checkOutput("ar_interval", n, (i == 0) ? 111 : 128);
         checkOutput("ar_expired", expired, (e == 2) ? 1 : 0);
         checkOutput("ar_running", running, 1);
         clkStep();
         checkOutput("ar_expired_next", expired, 0);
         checkOutput("ar_state", state, 1);
      end
`endif

      $display("[TB] pause and resume");
      alignPhase();
      applyStimulus(1'b1, 16'd5, 1'b0, 1'b0);
      applyStimulus(1'b0, 16'd0, 1'b1, 1'b0);
      oneTick();
      oneTick();
      checkOutput("pre_after_two", dut.pre_cnt, 2);
      applyStimulus(1'b0, 16'd0, 1'b0, 1'b1);
      checkOutput("paused_state", state, 2);
      checkOutput("paused_running", running, 0);
      repeat (500) clkStep();
      checkOutput("paused_count", count, 5);
      checkOutput("paused_pre", dut.pre_cnt, 2);
      applyStimulus(1'b0, 16'd0, 1'b0, 1'b1);
      checkOutput("paused_pause_noop", state, 2);
      alignPhase();
      applyStimulus(1'b0, 16'd0, 1'b1, 1'b0);
      checkOutput("resume_state", state, 1);
      oneTick();
      checkOutput("resume_tick3_count", count, 5);
      oneTick();
      checkOutput("resume_tick4_count", count, 4);

      $display("[TB] pause on the step tick");
      repeat (3) oneTick();
      checkOutput("pre_before_step", dut.pre_cnt, 3);
      while (ph != 16) clkStep();
      applyStimulus(1'b0, 16'd0, 1'b0, 1'b1);
      checkOutput("step_pause_count", count, 4);
      checkOutput("step_pause_state", state, 2);
      checkOutput("step_pause_pre", dut.pre_cnt, 3);

      $display("[TB] reset mid-run");
      alignPhase();
      applyStimulus(1'b0, 16'd0, 1'b1, 1'b0);
      checkOutput("rerun_state", state, 1);
      reset = 1'b1;
      clkStep();
      reset = 1'b0;
      checkOutput("midrun_reset_state", state, 0);
      checkOutput("midrun_reset_count", count, 0);
      checkOutput("midrun_reset_running", running, 0);

      $display("[TB] load overrides start in RUN");
      alignPhase();
      applyStimulus(1'b1, 16'd7, 1'b0, 1'b0);
      applyStimulus(1'b0, 16'd0, 1'b1, 1'b0);
      oneTick();
      checkOutput("run7_count", count, 7);
      applyStimulus(1'b1, 16'd2, 1'b1, 1'b1);
      checkOutput("reload_count", count, 2);
      checkOutput("reload_state", state, 0);
      checkOutput("reload_pre", dut.pre_cnt, 0);
      applyStimulus(1'b1, 16'd0, 1'b0, 1'b0);
      applyStimulus(1'b0, 16'd0, 1'b1, 1'b0);
      checkOutput("zero_start_state", state, 0);
      checkOutput("zero_start_running", running, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/slow_tick_timer.md
# slow_tick_timer

Programmable down-counting timer driven by the divided user clock. It sits directly downstream of the clock divider: it samples `usr_clk` (a clk-domain register output toggling every 16 clk cycles) inside the `clk` domain and turns each rising edge into a single-cycle tick. It then counts a loaded value down to zero, one step per `PRESCALE` ticks, with start/pause/reload control for the game-logic layer. No logic is clocked by `usr_clk` itself.

## Interface
- `WIDTH`, 16, width of count and load value
- `PRESCALE`, 4, `usr_clk` rising edges per count step (≥1)
- `clk`  in  1  system clock
- `reset`  in  1  synchronous, active-high; clock clk
- `usr_clk`  in  1  divided clock from upstream divider, same-domain register output
- `load`  in  1  load `load_value` into count (level sampled each clk)
- `load_value`  in  WIDTH  value to load
- `start`  in  1  begin/resume counting
- `pause`  in  1  suspend counting
- `count`  out  WIDTH  current remaining count
- `state`  out  2  IDLE=0, RUN=1, PAUSED=2, DONE=3
- `running`  out  1  high iff state==RUN
- `expired`  out  1  one-clk pulse on reaching zero

## Operation
- Edge detect: `usr_q` <= `usr_clk` every cycle, including during reset, so there is no spurious tick after reset. `tick` = `usr_clk & ~usr_q`, combinational.
- Prescaler `pre_cnt` runs 0..PRESCALE-1 and advances only on `tick` in RUN. `step` = `tick` & (`pre_cnt`==PRESCALE-1); on `step`, `pre_cnt` wraps to 0.
- Priority, highest first: reset, load, pause, start, step.
- `load` (any state): `count`<=`load_value`, `reload_reg`<=`load_value`, `pre_cnt`<=0, state<=IDLE.
- IDLE: `start` with `count`!=0 moves to RUN. `start` with `count`==0 is ignored.
- RUN: `pause` moves to PAUSED. A tick in the same cycle is discarded and `pre_cnt` is held. `step` decrements `count`; when `count`==1 on `step`, `count` becomes 0, the state moves to DONE, and `expired`=1 for that next cycle only.
- PAUSED: `start` moves to RUN with `pre_cnt` retained. `pause` is a no-op.
- DONE: holds `count`=0. Only `load` or reset leave DONE; `start` and `pause` are ignored.
- `count` never wraps below 0.

## Timing
- Reset values: `count`=0, `state`=IDLE, `running`=0, `expired`=0, `pre_cnt`=0, `reload_reg`=0.
- All outputs are registered.
- `tick` is valid in the cycle where `usr_clk`=1 and `usr_q`=0. `count` updates at the following clk edge, giving 1 clk latency.
- With the upstream period of 32 clk, one step occurs every 32·PRESCALE clk (128 at default).
- `expired` rises on the same edge at which `count` becomes 0 and falls one clk later.
- Control inputs take effect at the next clk edge. `start`, `pause` and `load` asserted together resolve to `load`.
- Reset mid-run returns to IDLE on the next edge, regardless of `usr_clk`.

## Configuration
- `TIMER_AUTORELOAD_EN` defined: on the terminal step in RUN, `count`<=`reload_reg` and the state stays RUN. `expired` still pulses for 1 clk, and `pre_cnt` wraps normally. If `reload_reg`==0, the block goes to DONE instead.
- `TIMER_AUTORELOAD_EN` undefined: terminal step goes to DONE as described in Operation. `reload_reg` may be omitted.

## Test plan
- Reset with `usr_clk` held 1, then release -> no tick; `count`=0, `state`=0, `expired`=0.
- Load 3, start, `usr_clk` period 32 clk, PRESCALE=4 -> `count` 3→2→1→0 at 128-clk intervals; `expired` high exactly 1 clk; `state`=3.
- Load 5, start, pause after 2 ticks for 500 clk, then start -> no decrement while paused; the first step after resume comes after 2 more ticks.
- `pause` asserted in the exact cycle of the step tick -> `count` unchanged, `state`=2, `pre_cnt` still 3.
- Load 2 while RUN with `count`=7, with `start` held the same cycle -> `count`=2, `state`=IDLE; start on `count`=0 in IDLE -> stays IDLE.
- With `TIMER_AUTORELOAD_EN`: load 2, start -> `count` sequence 2,1,2,1,… with an `expired` pulse on each reload and `running` continuously 1.
